// File: rtl/lalu_pkg.sv
// Shared types and constants for the halt-triggered cycle report transmitter.
package lalu_pkg;

  typedef enum logic [2:0] {IDLE, ARM, START, DATA, STOP} rpt_state_t;

  // Frame-level sequencing in the top; bit-level timing lives in uart_byte_tx.
  typedef enum logic [1:0] {FRAME_IDLE, FRAME_ARM, FRAME_SEND} frame_state_t;

  localparam logic [7:0] ASCII_CR     = 8'h0D;
  localparam logic [7:0] ASCII_LF     = 8'h0A;
  localparam int         REPORT_BYTES = 6;

endpackage

// File: rtl/uart_byte_tx.sv
// UART 8N1 byte serializer: a byte accepted on start&&ready drives its start bit from the next edge.
// ready is also high in the last stop-bit cycle, so consecutive bytes run back-to-back.
module uart_byte_tx
  import lalu_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready,
  output logic       stopEnd
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  rpt_state_t        state, stateNext;
  logic [BAUD_W-1:0] baud, baudNext;
  logic [2:0]        bitIdx, bitIdxNext;
  logic [7:0]        shReg, shRegNext;
  logic              txR, txNext;
  logic              bitEnd;

  assign bitEnd  = (baud == BAUD_LAST);
  assign stopEnd = (state == STOP) && bitEnd;
  assign ready   = (state == IDLE) || stopEnd;
  assign tx      = txR;

  always_comb begin
    stateNext  = state;
    baudNext   = '0;
    bitIdxNext = bitIdx;
    shRegNext  = shReg;
    if (state != IDLE) begin
      baudNext = bitEnd ? '0 : baud + 1'b1;
    end
    case (state)
      START: begin
        if (bitEnd) begin
          stateNext  = DATA;
          bitIdxNext = '0;
        end
      end
      DATA: begin
        if (bitEnd) begin
          shRegNext = {1'b0, shReg[7:1]};
          if (bitIdx == 3'd7) begin
            stateNext = STOP;
          end else begin
            bitIdxNext = bitIdx + 3'd1;
          end
        end
      end
      STOP: begin
        if (bitEnd) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
    if (start && ready) begin
      stateNext = START;
      shRegNext = data;
      baudNext  = '0;
    end
    // Line level is registered from the next state so tx never glitches between bits.
    txNext = 1'b1;
    if (stateNext == START) begin
      txNext = 1'b0;
    end else if (stateNext == DATA) begin
      txNext = shRegNext[0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      baud   <= '0;
      bitIdx <= '0;
      shReg  <= '0;
      txR    <= 1'b1;
    end else begin
      state  <= stateNext;
      baud   <= baudNext;
      bitIdx <= bitIdxNext;
      shReg  <= shRegNext;
      txR    <= txNext;
    end
  end

endmodule

// File: rtl/cycle_report_tx.sv
// On a rising halt, latches the frozen cycle count and sends it once over UART as 4 hex digits + CR LF.
// First start bit 2 edges after the trigger; done pulses as the last stop bit ends.
module cycle_report_tx
  import lalu_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt,
  input  logic [15:0] cycle_count,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] LAST_BYTE = 3'(REPORT_BYTES - 1);

  frame_state_t state, stateNext;
  logic         haltQ;
  logic         trigger;
  logic [15:0]  cntR, cntNext;
  logic [2:0]   byteIdx, byteIdxNext;
  logic         doneR, doneNext;
  logic         byteStart;
  logic [7:0]   byteData;
  logic         txReady;
  logic         txStopEnd;

  function automatic logic [7:0] hexAscii(input logic [3:0] n);
    if (n < 4'd10) begin
      return 8'h30 + {4'h0, n};
    end
    return 8'h37 + {4'h0, n};
  endfunction

  function automatic logic [7:0] frameByte(input logic [15:0] cnt, input logic [2:0] idx);
    case (idx)
      3'd0:    return hexAscii(cnt[15:12]);
      3'd1:    return hexAscii(cnt[11:8]);
      3'd2:    return hexAscii(cnt[7:4]);
      3'd3:    return hexAscii(cnt[3:0]);
      3'd4:    return ASCII_CR;
      default: return ASCII_LF;
    endcase
  endfunction

  assign trigger = halt & ~haltQ;
  assign busy    = (state != FRAME_IDLE);
  assign done    = doneR;

  always_comb begin
    stateNext   = state;
    cntNext     = cntR;
    byteIdxNext = byteIdx;
    doneNext    = 1'b0;
    byteStart   = 1'b0;
    byteData    = frameByte(cntR, byteIdx);
    case (state)
      FRAME_IDLE: begin
        if (trigger) begin
          stateNext = FRAME_ARM;
        end
      end
      // The counter stops on the trigger edge itself, so the count is sampled one edge later.
      FRAME_ARM: begin
        cntNext     = cycle_count;
        byteIdxNext = '0;
        byteStart   = txReady;
        byteData    = frameByte(cycle_count, 3'd0);
        stateNext   = FRAME_SEND;
      end
      FRAME_SEND: begin
        if (txStopEnd) begin
          if (byteIdx < LAST_BYTE) begin
            byteIdxNext = byteIdx + 3'd1;
            byteStart   = 1'b1;
            byteData    = frameByte(cntR, byteIdx + 3'd1);
          end else begin
            stateNext = FRAME_IDLE;
            doneNext  = 1'b1;
          end
        end
      end
      default: stateNext = FRAME_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= FRAME_IDLE;
      haltQ   <= 1'b0;
      cntR    <= '0;
      byteIdx <= '0;
      doneR   <= 1'b0;
    end else begin
      state   <= stateNext;
      haltQ   <= halt;
      cntR    <= cntNext;
      byteIdx <= byteIdxNext;
      doneR   <= doneNext;
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) uByteTx (
    .clk    (clk),
    .rst    (rst),
    .start  (byteStart),
    .data   (byteData),
    .tx     (tx),
    .ready  (txReady),
    .stopEnd(txStopEnd)
  );

endmodule

// File: tb/tb_cycle_report_tx.sv
// Scoreboarded bench: two DUTs (4 and 1 clocks per bit), a UART decoder/done monitor checks queued expectations.
module tb_cycle_report_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt4, halt1;
  logic [15:0] cc4, cc1;
  logic        tx4, tx1, busy4, busy1, done4, done1;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  int qByte0[$], qByte1[$], qFall0[$], qFall1[$], qDone0[$], qDone1[$];

  bit         active[2];
  int         kCnt[2];
  int         byteCnt[2];
  logic [7:0] sh[2];
  int         doneCnt[2];
  logic       prevBusy[2];

  cycle_report_tx #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst(rst), .halt(halt4), .cycle_count(cc4),
    .tx(tx4), .busy(busy4), .done(done4)
  );

  cycle_report_tx #(.CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .halt(halt1), .cycle_count(cc1),
    .tx(tx1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    tests++;
    fails++;
    $display("FAIL %s: got %0h with nothing expected (cycle %0d)", name, act, cyc);
  endtask

  // kind: 0 = decoded byte, 1 = cycle of first tx fall, 2 = cycle of done
  task automatic pushExp(input int ch, input int kind, input int v);
    case ({ch[0], kind[1:0]})
      3'b000: qByte0.push_back(v);
      3'b001: qFall0.push_back(v);
      3'b010: qDone0.push_back(v);
      3'b100: qByte1.push_back(v);
      3'b101: qFall1.push_back(v);
      default: qDone1.push_back(v);
    endcase
  endtask

  task automatic popExp(input int ch, input int kind, output int v, output bit ok);
    ok = 1'b0;
    v  = 0;
    case ({ch[0], kind[1:0]})
      3'b000: if (qByte0.size() > 0) begin v = qByte0.pop_front(); ok = 1'b1; end
      3'b001: if (qFall0.size() > 0) begin v = qFall0.pop_front(); ok = 1'b1; end
      3'b010: if (qDone0.size() > 0) begin v = qDone0.pop_front(); ok = 1'b1; end
      3'b100: if (qByte1.size() > 0) begin v = qByte1.pop_front(); ok = 1'b1; end
      3'b101: if (qFall1.size() > 0) begin v = qFall1.pop_front(); ok = 1'b1; end
      default: if (qDone1.size() > 0) begin v = qDone1.pop_front(); ok = 1'b1; end
    endcase
  endtask

  // Called between edges; the next posedge is E0, so tx falls at cyc+2 and done comes 60 bit times later.
  task automatic pushFrame(input int ch, input logic [31:0] ascii, input int nBytes, input bit withDone);
    int c;
    int cpb;
    c   = cyc;
    cpb = (ch == 0) ? 4 : 1;
    pushExp(ch, 1, c + 2);
    for (int i = 0; i < nBytes; i++) begin
      if (i < 4)       pushExp(ch, 0, int'(ascii[31-8*i -: 8]));
      else if (i == 4) pushExp(ch, 0, 32'h0D);
      else             pushExp(ch, 0, 32'h0A);
    end
    if (withDone) pushExp(ch, 2, c + 2 + 60 * cpb);
  endtask

  task automatic startFrame(input int ch, input logic [31:0] ascii, input int nBytes, input bit withDone);
    if (ch == 0) halt4 = 1'b1; else halt1 = 1'b1;
    pushFrame(ch, ascii, nBytes, withDone);
    @(negedge clk);
    check($sformatf("busy_before_e0_ch%0d", ch), (ch == 0) ? busy4 : busy1, 1'b0);
    @(negedge clk);
    check($sformatf("busy_after_e0_ch%0d", ch), (ch == 0) ? busy4 : busy1, 1'b1);
  endtask

  task automatic waitDone(input int ch, input int limit);
    int d0;
    int n;
    d0 = doneCnt[ch];
    n  = 0;
    while (doneCnt[ch] == d0 && n < limit) begin
      @(negedge clk);
      #1;
      n++;
    end
    check($sformatf("done_seen_ch%0d", ch), doneCnt[ch] != d0, 1'b1);
  endtask

  // Monitor: decodes each UART line mid-bit and checks done timing against the queues.
  always @(negedge clk) begin
    for (int ch = 0; ch < 2; ch++) begin
      int   cpb;
      int   j;
      int   v;
      bit   ok;
      logic txb, busyB, doneB;
      cpb   = (ch == 0) ? 4 : 1;
      txb   = (ch == 0) ? tx4 : tx1;
      busyB = (ch == 0) ? busy4 : busy1;
      doneB = (ch == 0) ? done4 : done1;
      if (rst) begin
        active[ch]  = 1'b0;
        byteCnt[ch] = 0;
        kCnt[ch]    = 0;
      end else begin
        if (!active[ch] && txb == 1'b0) begin
          active[ch] = 1'b1;
          kCnt[ch]   = 0;
          if (byteCnt[ch] % 6 == 0) begin
            popExp(ch, 1, v, ok);
            if (!ok) unexpected($sformatf("unexpected_frame_ch%0d", ch), cyc);
            else     check($sformatf("tx_fall_cycle_ch%0d", ch), cyc, v);
          end
        end
        if (active[ch]) begin
          if (kCnt[ch] % cpb == cpb / 2) begin
            j = kCnt[ch] / cpb;
            if (j == 0) begin
              check($sformatf("start_bit_ch%0d", ch), txb, 1'b0);
            end else if (j <= 8) begin
              sh[ch][j-1] = txb;
            end else begin
              check($sformatf("stop_bit_ch%0d", ch), txb, 1'b1);
              popExp(ch, 0, v, ok);
              if (!ok) unexpected($sformatf("unexpected_byte_ch%0d", ch), sh[ch]);
              else     check($sformatf("byte%0d_ch%0d", byteCnt[ch] % 6, ch), sh[ch], v);
              active[ch] = 1'b0;
              byteCnt[ch]++;
            end
          end
          kCnt[ch]++;
        end
      end
      if (doneB) begin
        doneCnt[ch]++;
        popExp(ch, 2, v, ok);
        if (!ok) unexpected($sformatf("unexpected_done_ch%0d", ch), cyc);
        else     check($sformatf("done_cycle_ch%0d", ch), cyc, v);
        check($sformatf("busy_at_done_ch%0d", ch), busyB, 1'b0);
        check($sformatf("busy_before_done_ch%0d", ch), prevBusy[ch], 1'b1);
      end
      prevBusy[ch] = busyB;
    end
  end

  initial begin
    int d0;
    rst   = 1'b1;
    halt4 = 1'b0;
    halt1 = 1'b0;
    cc4   = 16'h0000;
    cc1   = 16'h0000;
    for (int ch = 0; ch < 2; ch++) begin
      doneCnt[ch]  = 0;
      prevBusy[ch] = 1'b0;
      sh[ch]       = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx4", tx4, 1'b1);
    check("reset_busy4", busy4, 1'b0);
    check("reset_done4", done4, 1'b0);
    check("reset_tx1", tx1, 1'b1);
    check("reset_busy1", busy1, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 0x1234 -> "1234\r\n"
    cc4 = 16'h1234;
    startFrame(0, 32'h31323334, 6, 1'b1);
    waitDone(0, 300);
    halt4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Latched 0xABCD, bus changes to 0xFFFF right after E1
    cc4 = 16'hABCD;
    startFrame(0, 32'h41424344, 6, 1'b1);
    @(posedge clk);
    #1;
    cc4 = 16'hFFFF;
    waitDone(0, 300);
    halt4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // halt held for >1000 cycles gives one frame; a fresh edge gives another
    d0 = doneCnt[0];
    startFrame(0, 32'h46464646, 6, 1'b1);
    waitDone(0, 300);
    repeat (800) @(posedge clk);
    #1;
    check("held_halt_one_frame", doneCnt[0] - d0, 1);
    halt4 = 1'b0;
    @(posedge clk);
    #1;
    startFrame(0, 32'h46464646, 6, 1'b1);
    waitDone(0, 300);
    halt4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // halt re-pulsed during byte 2 is ignored
    cc4 = 16'h0F9E;
    d0  = doneCnt[0];
    startFrame(0, 32'h30463945, 6, 1'b1);
    repeat (95) @(posedge clk);
    #1;
    halt4 = 1'b0;
    @(posedge clk);
    #1;
    halt4 = 1'b1;
    waitDone(0, 300);
    halt4 = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("repulse_one_frame", doneCnt[0] - d0, 1);

    // Reset in the middle of byte 1, halt still high across the release
    cc4 = 16'h5A3C;
    startFrame(0, 32'h35413343, 1, 1'b0);
    repeat (56) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midframe_rst_tx", tx4, 1'b1);
    check("midframe_rst_busy", busy4, 1'b0);
    check("midframe_rst_done", done4, 1'b0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    pushFrame(0, 32'h35413343, 6, 1'b1);
    waitDone(0, 300);
    halt4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // One clock per bit, count 0x0000
    cc1 = 16'h0000;
    startFrame(1, 32'h30303030, 6, 1'b1);
    waitDone(1, 100);
    halt1 = 1'b0;

    repeat (20) @(posedge clk);
    #1;
    check("leftover_bytes_ch0", qByte0.size(), 0);
    check("leftover_bytes_ch1", qByte1.size(), 0);
    check("leftover_done", qDone0.size() + qDone1.size(), 0);
    check("leftover_fall", qFall0.size() + qFall1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cycle_report_tx.md
# cycle_report_tx

Downstream consumer of the 16-bit cycle counter output. When the CPU halts, the block captures the frozen cycle count and transmits it once as an ASCII report on a UART 8N1 line. The frame is four uppercase hex digits, MSB first, followed by CR LF. It gives the board a pin-level readout of program runtime without a display.

## Interface
- `CLKS_PER_BIT`, default 16, clock cycles per UART bit; legal range 1–65535.
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `halt` in 1: CPU halt level, the same signal that drives the cycle counter's halt input.
- `cycle_count` in 16: cycle counter output bus.
- `tx` out 1: UART serial line, idle high.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle pulse when the final stop bit completes.

## Operation
- Reset values (async, immediate): `tx`=1, `busy`=0, `done`=0, state=IDLE, `halt_q`=0, byte index=0, bit index=0, baud counter=0.
- `halt_q` registers `halt` every cycle, in every state. A trigger occurs when `halt & ~halt_q` is true.
- FSM states:
  - IDLE: on trigger, go to ARM. No other exit.
  - ARM: one cycle, unconditional. Latch `cycle_count` into `cnt_r`, set byte index to 0, go to START.
    - ARM exists because the cycle counter increments on the same edge that latches halt. The count is stable only from the edge after the trigger.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
  - DATA: `tx`=current byte[bit index] (LSB first), each bit held `CLKS_PER_BIT` cycles. After bit 7, go to STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles. Then:
    - if byte index < 5: increment byte index, go to START;
    - otherwise: go to IDLE and assert `done` for that one cycle.
- Byte sequence by index:
  - indices 0..3: hex digits `cnt_r[15:12]`, `[11:8]`, `[7:4]`, `[3:0]`;
  - index 4: 0x0D;
  - index 5: 0x0A.
- Nibble-to-ASCII mapping:
  - 0–9 map to 0x30 + n;
  - A–F map to 0x41 + (n − 10).
- Triggers outside IDLE are ignored. This includes a halt that drops and re-rises mid-frame; no report is queued.
- `halt` held high gives exactly one report. A new report requires `halt` to fall and rise again while in IDLE.
- Changes on `cycle_count` after ARM have no effect on the frame in flight.
- Reset mid-frame: `tx` returns to 1 immediately, `done` is not pulsed, and the partial frame is abandoned.
  - `halt_q`=0 after reset, so a `halt` still high when reset releases produces a trigger on the first edge.
- Baud counter width is `$clog2(CLKS_PER_BIT)`, minimum 1 bit.
  - `CLKS_PER_BIT`=1 is legal: every bit lasts one cycle.

## Timing
- Let E0 be the edge that samples the trigger.
  - State is ARM after E0.
  - At E1, `cnt_r` is latched and `tx` falls (start bit of byte 0).
- Each byte occupies 10·`CLKS_PER_BIT` cycles; bytes are back-to-back with no idle gap.
- The last stop bit ends at edge E1 + 60·`CLKS_PER_BIT`.
  - At that edge, state becomes IDLE and `done`=1 for exactly one cycle.
  - `busy` falls at that same edge.
- `busy` is high from E0 until the `done` edge. Latency from trigger to first start bit is 2 edges.
- The earliest re-trigger is the edge after `done`, provided `halt` has toggled.

## Structure
- Shared package `lalu_pkg` holds:
  - state enum `rpt_state_t` (IDLE, ARM, START, DATA, STOP);
  - constants `ASCII_CR`=8'h0D, `ASCII_LF`=8'h0A, `REPORT_BYTES`=6.
- One natural sub-module, `uart_byte_tx`: start/data/stop serializer with a `start`/`ready` handshake and its own baud counter, parameterized by `CLKS_PER_BIT`.
  - The top keeps the halt-edge detection, the ARM latch, byte sequencing, and the hex conversion function.
  - A flat implementation is also acceptable, provided the cycle behaviour is identical.

## Test plan
- `cycle_count`=16'h1234, `CLKS_PER_BIT`=4, raise `halt` → decoded bytes 31 32 33 34 0D 0A; `done` pulses exactly 240 cycles after `tx` first falls; `busy` spans E0..done.
- `cycle_count`=16'hABCD, then `cycle_count`=16'hFFFF from E1 onward → bytes 41 42 43 44 0D 0A (latched value used, later changes ignored).
- `halt` held high for 1000 cycles → one frame only; drop `halt`, re-raise after `done` → second identical frame.
- Pulse `halt` low→high during byte 2 → no extra frame, no glitch on `tx`, `done` at the nominal cycle.
- Assert `rst` mid-DATA of byte 1 → `tx`=1, `busy`=0 immediately, no `done`; release `rst` with `halt`=1 → a full frame starts 2 edges later.
- `CLKS_PER_BIT`=1, `cycle_count`=16'h0000 → bytes 30 30 30 30 0D 0A in exactly 60 cycles, followed by `done`.
